uart_tx_buffered: RTL and testbench

Parametrised, buffered UART transmitter: serialises words of configurable width with optional parity and 1 or 2 stop bits, and holds pending words in an internal FIFO behind a valid/ready write port. Sits between on-chip producers (debug/log streamers, command responders) and the board TX pin. Successive FIFO entries go out as back-to-back frames with no idle gap between them.

---
 rtl/uart_tx_buffered.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO of DATA_BITS words serialised as start/data/[parity]/stop frames.
// Latency: a write into an empty idle block drives the start bit on the next edge.
// Backpressure: data_ready is low when the FIFO is full or reset is high; writes offered while it is low are dropped.
//
// Ports:
//   clk, reset          - system clock; synchronous active-high reset
//   data_in/data_valid  - write port, accepted when data_valid && data_ready
//   data_ready          - FIFO not full (from the registered level)
//   parity_mode         - 00/11 none, 01 even, 10 odd; latched at each frame start
//   tx                  - serial line, idle high
//   busy                - frame in flight or FIFO non-empty
//   frame_done          - one-cycle pulse after each frame's last stop bit
//   fifo_level          - number of stored entries
//
// Build option: define UART_TX_PARITY_EN to compile in the parity bit;
// without it parity_mode is ignored and every frame is sent without parity.

module uart_tx_buffered #(
    parameter int BAUD_RATE    = 9_600,
    parameter int SYS_CLK_FREQ = 48_000_000,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [1:0]                    parity_mode,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE;
    localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [TW-1:0] TIMER_RELOAD = TW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] LAST_DATA    = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP    = IW'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL_LEVEL   = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;

    // Transmit FSM and datapath
    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 tx_q, tx_d;
    logic                 frame_done_q, frame_done_d;

`ifdef UART_TX_PARITY_EN
    logic [1:0]           par_mode_q, par_mode_d;
    logic                 par_on;
    logic                 parity_bit;
    assign par_on     = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    // Even parity is the XOR of the data; odd mode (10) inverts it.
    assign parity_bit = (^word_q) ^ par_mode_q[1];
`else
    logic                 unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    logic push, pop, fifo_empty, bit_end, frame_end;

    assign data_ready = !reset && (level_q != FULL_LEVEL);
    assign push       = data_valid && data_ready;
    assign fifo_empty = (level_q == '0);
    assign bit_end    = (timer_q == '0);
    assign frame_end  = (state_q == ST_STOP) && bit_end && (bit_idx_q == LAST_STOP);
    // Pop either from idle or on the last stop-bit edge, so frames run back to back.
    assign pop        = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign frame_done = frame_done_q;
    assign fifo_level = level_q;

    // FIFO next-state
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= TIMER_RELOAD;
            bit_idx_q    <= '0;
            word_q       <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
`ifdef UART_TX_PARITY_EN
            par_mode_q   <= 2'b00;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            word_q       <= word_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
`ifdef UART_TX_PARITY_EN
            par_mode_q   <= par_mode_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_START;
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end && (bit_idx_q == LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_on ? ST_PARITY : ST_STOP;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
            ST_STOP:  if (frame_end) state_d = fifo_empty ? ST_IDLE : ST_START;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic; tx is registered from the next state.
    always_comb begin
        timer_d = ((state_q == ST_IDLE) || bit_end) ? TIMER_RELOAD : timer_q - TW'(1);

        // bit_idx counts data bits in DATA and stop bits in STOP; it is 0 on entry to both.
        bit_idx_d = bit_idx_q;
        if (bit_end && (state_q == ST_DATA)) begin
            bit_idx_d = (bit_idx_q == LAST_DATA) ? '0 : bit_idx_q + IW'(1);
        end else if (bit_end && (state_q == ST_STOP)) begin
            bit_idx_d = (bit_idx_q == LAST_STOP) ? '0 : bit_idx_q + IW'(1);
        end

        word_d       = pop ? mem_q[rd_ptr_q] : word_q;
`ifdef UART_TX_PARITY_EN
        par_mode_d   = pop ? parity_mode : par_mode_q;
`endif
        frame_done_d = frame_end;

        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = word_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_bit;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: two instances (8N1 and 7-data/2-stop, BIT_PERIOD=16, depth 4)
// driven with directed and random writes; every cycle each output is compared with a
// frame-level reference model (FIFO queue + position within the current frame).

module tb_uart_tx_buffered;

    localparam int BP    = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       dv;
    logic [1:0]       rdy;
    logic [1:0]       txv;
    logic [1:0]       bsy;
    logic [1:0]       fdn;
    logic [1:0][1:0]  pm;
    logic [1:0][2:0]  lvl;
    logic [1:0][7:0]  din;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .BAUD_RATE(1), .SYS_CLK_FREQ(16), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]), .data_ready(rdy[0]),
        .parity_mode(pm[0]), .tx(txv[0]), .busy(bsy[0]), .frame_done(fdn[0]), .fifo_level(lvl[0])
    );

    uart_tx_buffered #(
        .BAUD_RATE(1), .SYS_CLK_FREQ(16), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .reset(reset), .data_in(din[1][6:0]), .data_valid(dv[1]), .data_ready(rdy[1]),
        .parity_mode(pm[1]), .tx(txv[1]), .busy(bsy[1]), .frame_done(fdn[1]), .fifo_level(lvl[1])
    );

    // Reference model state
    int unsigned mq [2][$];   // queued words
    int          cyc [2];     // cycle within current frame, -1 when line idle
    int          fw [2];      // word of current frame
    int          fm [2];      // parity mode latched for current frame
    bit          fd_exp [2];
    bit          chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int db_of(input int d);
        return (d == 0) ? 8 : 7;
    endfunction

    function automatic int sb_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit par_used(input int mode);
        return PAR_EN && ((mode == 1) || (mode == 2));
    endfunction

    function automatic int frame_len(input int d, input int mode);
        return (1 + db_of(d) + (par_used(mode) ? 1 : 0) + sb_of(d)) * BP;
    endfunction

    // Expected line level: which bit slot of the frame are we in?
    function automatic int exp_tx(input int d);
        int slot;
        int ones;
        if (cyc[d] < 0) return 1;
        slot = cyc[d] / BP;
        if (slot == 0) return 0;
        if (slot <= db_of(d)) return (fw[d] >> (slot - 1)) & 1;
        if (par_used(fm[d]) && (slot == db_of(d) + 1)) begin
            ones = 0;
            for (int i = 0; i < db_of(d); i++) ones += (fw[d] >> i) & 1;
            return (fm[d] == 2) ? 1 - (ones % 2) : (ones % 2);
        end
        return 1;
    endfunction

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("tx%0d", d), int'(txv[d]), exp_tx(d));
            check_eq($sformatf("busy%0d", d), int'(bsy[d]),
                     ((cyc[d] >= 0) || (mq[d].size() != 0)) ? 1 : 0);
            check_eq($sformatf("frame_done%0d", d), int'(fdn[d]), int'(fd_exp[d]));
            check_eq($sformatf("fifo_level%0d", d), int'(lvl[d]), mq[d].size());
            check_eq($sformatf("data_ready%0d", d), int'(rdy[d]),
                     (!reset && (mq[d].size() != DEPTH)) ? 1 : 0);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int  lev;
            bit  do_pop;
            bit  do_push;
            if (reset) begin
                mq[d].delete();
                cyc[d]    = -1;
                fd_exp[d] = 1'b0;
            end else begin
                lev       = mq[d].size();
                fd_exp[d] = 1'b0;
                do_pop    = 1'b0;
                if (cyc[d] < 0) begin
                    do_pop = (lev > 0);
                end else if (cyc[d] == frame_len(d, fm[d]) - 1) begin
                    fd_exp[d] = 1'b1;
                    do_pop    = (lev > 0);
                    cyc[d]    = -1;
                end else begin
                    cyc[d]++;
                end
                do_push = dv[d] && (lev != DEPTH);
                if (do_pop) begin
                    fw[d]  = mq[d].pop_front();
                    fm[d]  = int'(pm[d]);
                    cyc[d] = 0;
                end
                if (do_push) mq[d].push_back(int'(din[d]) & ((1 << db_of(d)) - 1));
            end
        end
    endtask

    // One clock: check outputs at the falling edge, drive inputs, then advance the model.
    task automatic run_cycle(input bit r, input bit [1:0] v, input bit [15:0] w, input bit [3:0] m);
        @(negedge clk);
        if (chk_en) compare_all();
        reset = r;
        dv    = v;
        din   = w;
        pm    = m;
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 2'b00, 16'($urandom()), 4'($urandom()));
    endtask

    task automatic rand_cycle(input int pct, input int rst_per_mille);
        bit       r;
        bit [1:0] v;
        r    = ($urandom_range(0, 999) < rst_per_mille);
        v[0] = ($urandom_range(0, 99) < pct);
        v[1] = ($urandom_range(0, 99) < pct);
        run_cycle(r, v, 16'($urandom()), 4'($urandom()));
    endtask

    initial begin
        reset = 1'b1;
        dv    = '0;
        din   = '0;
        pm    = '0;
        for (int d = 0; d < 2; d++) begin
            cyc[d]    = -1;
            fw[d]     = 0;
            fm[d]     = 0;
            fd_exp[d] = 1'b0;
        end

        for (int i = 0; i < 3; i++) run_cycle(1'b1, 2'b00, 16'h0000, 4'h0);

        // Single frames: 0xA5 (8N1) and 0x55 (7 data, 2 stop), no parity
        run_cycle(1'b0, 2'b11, {8'h55, 8'hA5}, 4'b0000);
        idle(200);

        // 0x07 with even then odd parity mode
        run_cycle(1'b0, 2'b11, {8'h07, 8'h07}, 4'b0101);
        idle(200);
        run_cycle(1'b0, 2'b11, {8'h07, 8'h07}, 4'b1010);
        idle(200);

        // Six consecutive writes from idle: five accepted, sixth hits a full FIFO
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 2'b11, 16'($urandom()), 4'($urandom()));
        idle(1000);

        // Reset during data bit 3 with entries queued, then a clean 0x3C frame
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 2'b11, 16'($urandom()), 4'b0000);
        idle(64);
        run_cycle(1'b1, 2'b00, 16'h0000, 4'h0);
        run_cycle(1'b0, 2'b11, {8'h3C, 8'h3C}, 4'b0000);
        idle(200);

        // Random traffic: sparse, dense, occasional resets
        for (int i = 0; i < 1500; i++) rand_cycle(2, 0);
        for (int i = 0; i < 1500; i++) rand_cycle(40, 1);
        idle(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
